// File: rtl/arm_shift_seq.sv
// Iterative ARM-semantics barrel-shift replacement: LSL/LSR/ASR/ROR/RRX with carry-out,
// up to SHIFT_STEP bits per cycle. Define ARM_SHIFT_SEQ_OVERLAP_EN to accept a new op while the result is consumed.
module arm_shift_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 8,
    parameter int SHIFT_STEP  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   carry_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   carry_out
);

    // Remaining-count width must hold DATA_WIDTH+1 (the over-shift clamp).
    localparam int CW = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);
    localparam logic [CW-1:0] W_C    = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_M = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] LSB_M = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_RRX = 3'b101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   work_q, dout_q;
    logic                    wc_q, cout_q;
    logic [CW-1:0]           rem_q;
    logic [2:0]              op_q;
    logic                    accept;

    // Acceptance decode: effective amount and the immediate carry for eff==0 ops.
    logic [31:0] sh, acc_eff;
    logic        acc_carry, acc_zero;

    always_comb begin
        sh        = 32'(shamt);
        acc_eff   = '0;
        acc_carry = carry_in;
        case (op)
            OP_LSL, OP_LSR, OP_ASR:
                acc_eff = (sh > 32'(DATA_WIDTH + 1)) ? 32'(DATA_WIDTH + 1) : sh;
            OP_ROR: begin
                acc_eff = sh % 32'(DATA_WIDTH);
                if (sh != '0 && acc_eff == '0) acc_carry = data_in[DATA_WIDTH-1];
            end
            OP_RRX:  acc_eff = 32'd1;
            default: acc_eff = '0;
        endcase
        acc_zero = (acc_eff == '0);
    end

    // One iteration: shift by n, carry is the last bit to leave the word.
    logic [CW-1:0]         n, nm1, rem_nxt;
    logic [DATA_WIDTH-1:0] st_data, tmp;
    logic                  st_carry;

    always_comb begin
        n        = (rem_q > STEP_C) ? STEP_C : rem_q;
        nm1      = n - 1'b1;
        rem_nxt  = rem_q - n;
        tmp      = '0;
        st_data  = work_q;
        st_carry = wc_q;
        case (op_q)
            OP_LSL: begin
                tmp      = work_q << nm1;
                st_data  = work_q << n;
                st_carry = |(tmp & MSB_M);
            end
            OP_LSR: begin
                tmp      = work_q >> nm1;
                st_data  = work_q >> n;
                st_carry = |(tmp & LSB_M);
            end
            OP_ASR: begin
                tmp      = $signed(work_q) >>> nm1;
                st_data  = $signed(work_q) >>> n;
                st_carry = |(tmp & LSB_M);
            end
            OP_ROR: begin
                st_data  = (work_q >> n) | (work_q << (W_C - n));
                st_carry = |(st_data & MSB_M);
            end
            OP_RRX: begin
                st_data  = {wc_q, work_q[DATA_WIDTH-1:1]};
                st_carry = |(work_q & LSB_M);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        out_valid = (state_q == DONE);
`ifdef ARM_SHIFT_SEQ_OVERLAP_EN
        in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
`else
        in_ready  = !rst && (state_q == IDLE);
`endif
        accept    = in_valid && in_ready;
        case (state_q)
            IDLE:  if (accept) state_d = acc_zero ? DONE : SHIFT;
            SHIFT: if (rem_nxt == '0) state_d = DONE;
            DONE: begin
                if (accept)         state_d = acc_zero ? DONE : SHIFT;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Working registers are separate from the output registers so partial shifts never reach data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            wc_q   <= 1'b0;
            rem_q  <= '0;
            op_q   <= '0;
            dout_q <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            work_q <= data_in;
            wc_q   <= carry_in;
            op_q   <= op;
            rem_q  <= acc_eff[CW-1:0];
            if (acc_zero) begin
                dout_q <= data_in;
                cout_q <= acc_carry;
            end
        end else if (state_q == SHIFT) begin
            work_q <= st_data;
            wc_q   <= st_carry;
            rem_q  <= rem_nxt;
            if (rem_nxt == '0) begin
                dout_q <= st_data;
                cout_q <= st_carry;
            end
        end
    end

    assign data_out  = dout_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_arm_shift_seq.sv
// Scoreboard bench for arm_shift_seq: directed ARM shift cases, latency, backpressure,
// mid-shift reset and a SHIFT_STEP=1 instance.
`timescale 1ns/1ps
module tb_arm_shift_seq;

`ifdef ARM_SHIFT_SEQ_OVERLAP_EN
    localparam logic OVL = 1'b1;
`else
    localparam logic OVL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, carry_in, out_valid, out_ready, carry_out;
    logic [2:0]  op;
    logic [7:0]  shamt;
    logic [31:0] data_in, data_out;

    logic        iv1, ir1, cin1, ov1, c1;
    logic [2:0]  op1;
    logic [7:0]  sh1;
    logic [31:0] din1, d1;

    int cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [31:0] d;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arm_shift_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(8), .SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .shamt(shamt), .data_in(data_in), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .carry_out(carry_out));

    arm_shift_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(8), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .shamt(sh1), .data_in(din1), .carry_in(cin1), .out_valid(ov1),
        .out_ready(1'b1), .data_out(d1), .carry_out(c1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request, wait (bounded) for the handshake, push the expectation.
    task automatic run_op(input logic [2:0] o, input logic [7:0] s, input logic [31:0] d,
                          input logic c, input logic [31:0] ed, input logic ec, input int el);
        exp_t e;
        op = o; shamt = s; data_in = d; carry_in = c; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        else begin
            e.d = ed; e.c = ec; e.lat = el; e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: samples just after the falling edge, once drivers have settled.
    initial begin
        bit seen = 0;
        int lat_m = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (out_valid && !seen && sb.size() > 0) begin
                    seen  = 1;
                    lat_m = cyc - sb[0].acc;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("data", data_out, e.d);
                        chk("carry", {31'd0, carry_out}, {31'd0, e.c});
                        chk("latency", lat_m, e.lat);
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        rst = 1; in_valid = 0; out_ready = 1; op = 0; shamt = 0; data_in = 0; carry_in = 0;
        iv1 = 0; op1 = 0; sh1 = 0; din1 = 0; cin1 = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_carry", carry_out, 0);
        rst = 0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        run_op(3'b001, 8'd4,   32'h0000_00FF, 1, 32'h0000_0FF0, 0, 2);
        run_op(3'b010, 8'd32,  32'h8000_0001, 0, 32'h0000_0000, 1, 5);
        run_op(3'b010, 8'd33,  32'h8000_0001, 0, 32'h0000_0000, 0, 6);
        run_op(3'b010, 8'd0,   32'h8000_0001, 1, 32'h8000_0001, 1, 1);
        run_op(3'b100, 8'd36,  32'h0000_0001, 1, 32'h1000_0000, 0, 2);
        run_op(3'b100, 8'd32,  32'h8000_0000, 0, 32'h8000_0000, 1, 1);
        run_op(3'b101, 8'd9,   32'h0000_0003, 1, 32'h8000_0001, 1, 2);
        run_op(3'b110, 8'd5,   32'h1234_5678, 0, 32'h1234_5678, 0, 1);
        run_op(3'b001, 8'd32,  32'h0000_0001, 0, 32'h0000_0000, 1, 5);
        run_op(3'b011, 8'd31,  32'h4000_0000, 0, 32'h0000_0000, 1, 5);
        run_op(3'b100, 8'd8,   32'h1234_5678, 1, 32'h7812_3456, 0, 2);
        run_op(3'b001, 8'd200, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 6);

        // Backpressure: hold the ASR result for 5 cycles.
        run_op(3'b011, 8'd200, 32'h8000_0000, 0, 32'hFFFF_FFFF, 1, 6);
        out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        chk("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_data", data_out, 32'hFFFF_FFFF);
            chk("bp_carry", carry_out, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        #0.5;
        chk("ovl_in_ready", in_ready, OVL);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready && sb.size() == 0) break;
        end

        // Reset pulse in the middle of an LSR by 32.
        op = 3'b010; shamt = 8'd32; data_in = 32'h8000_0001; carry_in = 0; in_valid = 1;
        #1;
        chk("mid_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_carry", carry_out, 0);
        rst = 0;
        #1;
        chk("mid_rel_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) chk("mid_no_result", out_valid, 0);
        end

        // SHIFT_STEP=1 instance: LSL by 3 takes 1+3 cycles.
        op1 = 3'b001; sh1 = 8'd3; din1 = 32'hFFFF_FFFF; cin1 = 0; iv1 = 1;
        #1;
        chk("s1_accept", ir1, 1);
        c0 = cyc;
        @(negedge clk);
        iv1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (ov1) break;
            @(negedge clk);
        end
        chk("s1_latency", cyc - c0, 4);
        chk("s1_data", d1, 32'hFFFF_FFF8);
        chk("s1_carry", c1, 1);

        // Back-to-back issue; with overlap the second op is taken as the first is consumed.
        @(negedge clk);
        run_op(3'b000, 8'd0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1, 1);
        run_op(3'b010, 8'd4, 32'h0000_00F8, 0, 32'h0000_000F, 1, 2);
        run_op(3'b101, 8'd0, 32'h0000_0002, 0, 32'h0000_0001, 0, 2);

        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
